// File: rtl/connect_four_move_input.sv
// connect_four_move_input
//   Front end for the connect_four game controller. Synchronizes and
//   debounces seven column buttons plus a drop button, keeps the highlighted
//   column as a one-hot code, and hands confirmed moves to the game
//   controller with a start/game_ready handshake while tracking the mover.
//
// Optional build macro: CF_COL_FULL_CHECK_EN
//   defined   : a drop on a column whose top cell is occupied is rejected here
//   undefined : col_full is ignored; the game controller flags it via game_error
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   btn_col[6:0] in   raw column buttons, bit 6 = leftmost column
//   btn_drop     in   raw drop/confirm button
//   game_ready   in   game controller waiting for a move
//   game_over    in   game controller in its end state
//   game_error   in   game controller error flag
//   col_full[6:0]in   column top cell occupied, same order as btn_col
//   player_input out  one-hot move column to the game controller
//   player       out  current mover, 0 = player 1, 1 = player 2
//   start        out  move-valid strobe
//   sel_col[6:0] out  highlighted column for display
//   reject       out  one-cycle pulse on an illegal or ignored drop
//
// state   | meaning
// --------+--------------------------------------------------------------
// SELECT  | choosing a column; drop presses are validated here
// ISSUE   | start high with player_input, waiting for game_ready to fall
// WAIT    | move handed over; waiting for the controller's verdict
module connect_four_move_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] btn_col,
  input  logic       btn_drop,
  input  logic       game_ready,
  input  logic       game_over,
  input  logic       game_error,
  input  logic [6:0] col_full,
  output logic [6:0] player_input,
  output logic       player,
  output logic       start,
  output logic [6:0] sel_col,
  output logic       reject
);

  localparam logic [15:0] DB_TC = 16'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  sync_q [SYNC_STAGES];
  logic [7:0]  sample;
  logic [15:0] db_cnt [8];
  logic [7:0]  db_level;
  logic [7:0]  press;
  logic [6:0]  col_pick;
  logic        col_blocked;
  logic [6:0]  sel_nxt, pin_nxt;
  logic        player_nxt, reject_nxt;

  // bit 7 carries the drop button, bits 6:0 the column buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {btn_drop, btn_col};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  // The counter sits at the terminal value for one cycle before the level
  // flips; the press pulse is taken from that cycle so the consumer sees the
  // press on the same edge that the debounced level rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (db_cnt[i] == DB_TC) begin
          db_level[i] <= ~db_level[i];
          db_cnt[i]   <= '0;
        end else if (sample[i] != db_level[i]) begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < 8; i++) press[i] = (db_cnt[i] == DB_TC) && !db_level[i];
  end

  // ascending scan, so the highest (leftmost) pressed column wins
  always_comb begin
    col_pick = '0;
    for (int i = 0; i < 7; i++) begin
      if (press[i]) begin
        col_pick    = '0;
        col_pick[i] = 1'b1;
      end
    end
  end

`ifdef CF_COL_FULL_CHECK_EN
  assign col_blocked = |(sel_col & col_full);
`else
  logic unused_col_full;
  assign col_blocked     = 1'b0;
  assign unused_col_full = ^col_full;
`endif

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_col;
    pin_nxt    = player_input;
    player_nxt = player;
    reject_nxt = 1'b0;
    case (state)
      S_SELECT: begin
        // drop is judged against the selection held before this cycle
        if (press[7]) begin
          if ((sel_col != 7'd0) && game_ready && !game_over && !col_blocked) begin
            state_nxt = S_ISSUE;
            pin_nxt   = sel_col;
          end else begin
            reject_nxt = 1'b1;
          end
        end
        if (|press[6:0]) sel_nxt = col_pick;
      end
      S_ISSUE: begin
        if (!game_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (game_error) begin
          reject_nxt = 1'b1;
          sel_nxt    = '0;
          pin_nxt    = '0;
          state_nxt  = S_SELECT;
        end else if (game_ready || game_over) begin
          player_nxt = ~player;
          sel_nxt    = '0;
          pin_nxt    = '0;
          state_nxt  = S_SELECT;
        end
      end
      default: state_nxt = S_SELECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_SELECT;
      sel_col      <= '0;
      player_input <= '0;
      player       <= 1'b0;
      reject       <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel_col      <= sel_nxt;
      player_input <= pin_nxt;
      player       <= player_nxt;
      reject       <= reject_nxt;
    end
  end

  assign start = (state == S_ISSUE);

endmodule
